// File: rtl/can_error_block.sv
// CAN receive-path error detector: stuff, delimiter and EOF form checks, one decision per sample point.
// Optional ERROR_STICKY_EN: once raised, ERROR holds until reset instead of timing out.
module can_error_block #(
  parameter int STUFF_LIMIT  = 5,
  parameter int EOF_LEN      = 7,
  parameter int ERR_FLAG_LEN = 6
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       F_STF,
  input  logic       EOF_Flag,
  input  logic       F_ACK_D,
  input  logic       F_CRC_D,
  output logic       ERROR,
  output logic [0:0] dbg_state
);

  localparam int RUN_W = $clog2(STUFF_LIMIT + 1);
  localparam int EOF_W = $clog2(EOF_LEN + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUFF_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [EOF_W-1:0] EOF_LOAD = EOF_W'(EOF_LEN - 1);

  localparam logic [0:0] ST_CHECK = 1'b0;
  localparam logic [0:0] ST_FLAG  = 1'b1;

  logic [0:0]       state;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             last_bit;
  logic             in_stf;
  logic [EOF_W-1:0] eof_cnt;
  logic [EOF_W-1:0] eof_next;

  logic stf_active;
  logic run_same;
  logic stuff_err;
  logic eof_active;
  logic eof_err;
  logic delim_err;
  logic any_err;

  // A run only continues if the previous bit was also inside the stuffed
  // region; the first in-window bit always starts a fresh run of one.
  always_comb begin
    stf_active = ~F_STF;
    run_same   = in_stf && (RX == last_bit);
    stuff_err  = stf_active && run_same && (run_cnt == RUN_MAX);
    run_next   = '0;
    if (stf_active) begin
      if (run_same) run_next = run_cnt + RUN_ONE;
      else          run_next = RUN_ONE;
    end
  end

  // The EOF_Flag bit itself is EOF bit 1, so it is checked on the spot and
  // the counter is left holding the bits still to come.
  always_comb begin
    eof_active = ~EOF_Flag || (eof_cnt != '0);
    eof_err    = eof_active && ~RX;
    eof_next   = '0;
    if (~EOF_Flag)            eof_next = EOF_LOAD;
    else if (eof_cnt != '0)   eof_next = eof_cnt - EOF_W'(1);
  end

  always_comb begin
    delim_err = (~F_ACK_D || ~F_CRC_D) && ~RX;
    any_err   = stuff_err || eof_err || delim_err;
  end

`ifdef ERROR_STICKY_EN
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state    <= ST_CHECK;
      run_cnt  <= '0;
      last_bit <= 1'b1;
      in_stf   <= 1'b0;
      eof_cnt  <= '0;
    end else begin
      last_bit <= RX;
      case (state)
        ST_CHECK: begin
          if (any_err) begin
            state   <= ST_FLAG;
            run_cnt <= '0;
            in_stf  <= 1'b0;
            eof_cnt <= '0;
          end else begin
            run_cnt <= run_next;
            in_stf  <= stf_active;
            eof_cnt <= eof_next;
          end
        end
        default: begin
          run_cnt <= '0;
          in_stf  <= 1'b0;
          eof_cnt <= '0;
        end
      endcase
    end
  end
`else
  localparam int FLAG_W = $clog2(ERR_FLAG_LEN + 1);
  localparam logic [FLAG_W-1:0] FLAG_LOAD = FLAG_W'(ERR_FLAG_LEN - 1);

  logic [FLAG_W-1:0] flag_cnt;

  // FLAG spans ERR_FLAG_LEN edges: the entry edge loads LEN-1 and the exit
  // edge is the one that finds the counter already at zero.
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state    <= ST_CHECK;
      run_cnt  <= '0;
      last_bit <= 1'b1;
      in_stf   <= 1'b0;
      eof_cnt  <= '0;
      flag_cnt <= '0;
    end else begin
      last_bit <= RX;
      case (state)
        ST_CHECK: begin
          if (any_err) begin
            state    <= ST_FLAG;
            flag_cnt <= FLAG_LOAD;
            run_cnt  <= '0;
            in_stf   <= 1'b0;
            eof_cnt  <= '0;
          end else begin
            run_cnt  <= run_next;
            in_stf   <= stf_active;
            eof_cnt  <= eof_next;
          end
        end
        default: begin
          run_cnt <= '0;
          in_stf  <= 1'b0;
          eof_cnt <= '0;
          if (flag_cnt == '0) state <= ST_CHECK;
          else                flag_cnt <= flag_cnt - FLAG_W'(1);
        end
      endcase
    end
  end
`endif

  assign ERROR     = (state == ST_FLAG);
  assign dbg_state = state;

endmodule

// File: tb/tb_can_error_block.sv
// Directed self-checking bench for can_error_block: reset, stuff, EOF, delimiter and flag-window cases.
// Expectations follow ERROR_STICKY_EN the same way the design build does.
module tb_can_error_block;

`ifdef ERROR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       SP = 1'b0;
  logic       reset;
  logic       RX;
  logic       F_STF;
  logic       EOF_Flag;
  logic       F_ACK_D;
  logic       F_CRC_D;
  logic       ERROR;
  logic [0:0] dbg_state;

  int checks = 0;
  int errors = 0;

  can_error_block dut (
    .SP        (SP),
    .reset     (reset),
    .RX        (RX),
    .F_STF     (F_STF),
    .EOF_Flag  (EOF_Flag),
    .F_ACK_D   (F_ACK_D),
    .F_CRC_D   (F_CRC_D),
    .ERROR     (ERROR),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 SP = ~SP;

  // drivers: inputs change 1 time unit after the edge, outputs sampled there too
  task automatic drive_bit(input logic rx, input logic stf, input logic eof,
                           input logic ack, input logic crc);
    RX = rx; F_STF = stf; EOF_Flag = eof; F_ACK_D = ack; F_CRC_D = crc;
    @(posedge SP);
    #1;
  endtask

  task automatic drive_idle(input int n, input logic rx);
    for (int i = 0; i < n; i++) drive_bit(rx, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic end_flag();
    if (STICKY) begin
      reset = 1'b0;
      #1;
      reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    RX = 1'b1; F_STF = 1'b1; EOF_Flag = 1'b1; F_ACK_D = 1'b1; F_CRC_D = 1'b1;
    repeat (3) @(posedge SP);
    #1;
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL reset_error: ERROR=%b expected 0", ERROR);
    end
    checks++;
    if (dbg_state !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%b expected 0", dbg_state);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_bit(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ERROR !== 1'b0) begin
        errors++; $display("FAIL idle_random bit %0d: ERROR=%b expected 0", i, ERROR);
      end
    end
  endtask

  task automatic test_stuff();
    logic exp;
    drive_idle(2, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      exp = (i == 6);
      checks++;
      if (ERROR !== exp) begin
        errors++; $display("FAIL stuff_run bit %0d: ERROR=%b expected %b", i, ERROR, exp);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      drive_idle(1, 1'b1);
      exp = (i < 6) || STICKY;
      checks++;
      if (ERROR !== exp) begin
        errors++; $display("FAIL stuff_flag_len cycle %0d: ERROR=%b expected %b", i, ERROR, exp);
      end
    end
    end_flag();
    drive_idle(1, 1'b1);
    // five equal bits followed by a toggle is legal
    for (int i = 1; i <= 6; i++) begin
      drive_bit((i == 6), 1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ERROR !== 1'b0) begin
        errors++; $display("FAIL stuff_toggle bit %0d: ERROR=%b expected 0", i, ERROR);
      end
    end
    // dominant bits before the stuffed region must not extend the run
    drive_idle(3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ERROR !== 1'b0) begin
        errors++; $display("FAIL stuff_prewindow bit %0d: ERROR=%b expected 0", i, ERROR);
      end
    end
    drive_idle(2, 1'b1);
  endtask

  task automatic test_eof();
    logic exp;
    logic rx;
    // EOF bits 1..5 with the 5th dominant
    for (int i = 1; i <= 5; i++) begin
      rx = (i != 5);
      drive_bit(rx, 1'b1, (i != 1), 1'b1, 1'b1);
      exp = (i == 5);
      checks++;
      if (ERROR !== exp) begin
        errors++; $display("FAIL eof_dominant bit %0d: ERROR=%b expected %b", i, ERROR, exp);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      drive_idle(1, 1'b1);
      exp = (i < 6) || STICKY;
      checks++;
      if (ERROR !== exp) begin
        errors++; $display("FAIL eof_flag_len cycle %0d: ERROR=%b expected %b", i, ERROR, exp);
      end
    end
    end_flag();
    drive_idle(1, 1'b1);
    // 7 recessive EOF bits, then a dominant bit just past the window
    for (int i = 1; i <= 8; i++) begin
      rx = (i != 8);
      drive_bit(rx, 1'b1, (i != 1), 1'b1, 1'b1);
      checks++;
      if (ERROR !== 1'b0) begin
        errors++; $display("FAIL eof_recessive bit %0d: ERROR=%b expected 0", i, ERROR);
      end
    end
    drive_idle(2, 1'b1);
    // restart at original bit 6; dominant at bit 7 of the restarted window
    drive_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_idle(4, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_idle(5, 1'b1);
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL eof_restart_pre: ERROR=%b expected 0", ERROR);
    end
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ERROR !== 1'b1) begin
      errors++; $display("FAIL eof_restart: ERROR=%b expected 1", ERROR);
    end
    drive_idle(6, 1'b1);
    end_flag();
    drive_idle(1, 1'b1);
  endtask

  task automatic test_delim();
    logic ack;
    logic crc;
    for (int sel = 0; sel < 2; sel++) begin
      ack = (sel != 0);
      crc = (sel == 0);
      drive_bit(1'b0, 1'b1, 1'b1, ack, crc);
      checks++;
      if (ERROR !== 1'b1) begin
        errors++; $display("FAIL delim_dominant sel %0d: ERROR=%b expected 1", sel, ERROR);
      end
      drive_idle(6, 1'b1);
      checks++;
      if (ERROR !== STICKY) begin
        errors++; $display("FAIL delim_flag_end sel %0d: ERROR=%b expected %b", sel, ERROR, STICKY);
      end
      end_flag();
      drive_idle(1, 1'b1);
      drive_bit(1'b1, 1'b1, 1'b1, ack, crc);
      checks++;
      if (ERROR !== 1'b0) begin
        errors++; $display("FAIL delim_recessive sel %0d: ERROR=%b expected 0", sel, ERROR);
      end
    end
    drive_idle(1, 1'b1);
  endtask

  task automatic test_flag_no_extend();
    logic rx;
    logic crc;
    // error at edge N, another CRC-delimiter error at N+2
    for (int i = 0; i <= 5; i++) begin
      rx  = !(i == 0 || i == 2);
      crc = rx;
      drive_bit(rx, 1'b1, 1'b1, 1'b1, crc);
      checks++;
      if (ERROR !== 1'b1) begin
        errors++; $display("FAIL flag_hold edge N+%0d: ERROR=%b expected 1", i, ERROR);
      end
    end
`ifdef ERROR_STICKY_EN
    drive_idle(10, 1'b1);
    checks++;
    if (ERROR !== 1'b1) begin
      errors++; $display("FAIL sticky_hold: ERROR=%b expected 1", ERROR);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL sticky_reset: ERROR=%b expected 0", ERROR);
    end
    reset = 1'b1;
    drive_idle(1, 1'b1);
`else
    // exit edge ignores its inputs; the next edge checks again
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL flag_exit_edge: ERROR=%b expected 0", ERROR);
    end
    drive_bit(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ERROR !== 1'b1) begin
      errors++; $display("FAIL flag_resume: ERROR=%b expected 1", ERROR);
    end
    drive_idle(6, 1'b1);
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL flag_resume_end: ERROR=%b expected 0", ERROR);
    end
    drive_idle(1, 1'b1);
`endif
  endtask

  task automatic test_simultaneous();
    logic exp;
    for (int i = 1; i <= 5; i++) drive_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ERROR !== 1'b1) begin
      errors++; $display("FAIL simul_rise: ERROR=%b expected 1", ERROR);
    end
    for (int i = 1; i <= 8; i++) begin
      drive_idle(1, 1'b1);
      exp = (i < 6) || STICKY;
      checks++;
      if (ERROR !== exp) begin
        errors++; $display("FAIL simul_single_flag cycle %0d: ERROR=%b expected %b", i, ERROR, exp);
      end
    end
    end_flag();
    drive_idle(1, 1'b1);
    // reset mid-flag clears ERROR without waiting for an edge
    drive_bit(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_idle(2, 1'b1);
    checks++;
    if (ERROR !== 1'b1) begin
      errors++; $display("FAIL midflag_pre: ERROR=%b expected 1", ERROR);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL midflag_reset: ERROR=%b expected 0", ERROR);
    end
    checks++;
    if (dbg_state !== 1'b0) begin
      errors++; $display("FAIL midflag_state: state=%b expected 0", dbg_state);
    end
    @(negedge SP);
    reset = 1'b1;
    drive_idle(2, 1'b1);
    checks++;
    if (ERROR !== 1'b0) begin
      errors++; $display("FAIL post_reset: ERROR=%b expected 0", ERROR);
    end
  endtask

  initial begin
    test_reset();
    test_stuff();
    test_eof();
    test_delim();
    test_flag_no_extend();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
